rs232_rx_fifo: RTL and testbench
================================

# rs232_rx_fifo

Receive buffer between the RS-232 receiver and the processor I/O bus. Captures each byte the receiver flags ready, acknowledges it with a one-cycle `done` pulse, and holds up to 2^DEPTH_LOG2 bytes in a show-ahead FIFO. The CPU reads them through I/O word 2 (data) and word 3 (status). This lets Oberon tolerate long interrupt-free stretches, such as disk traffic, without losing serial input.

## Interface
- `DEPTH_LOG2`, 4: log2 of FIFO depth (16 entries).
- `WIDTH`, 8: byte width.
- `clk`  in  1  system clock (25 MHz CPU clock).
- `rst`  in  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- `rx_rdy`  in  1  receiver byte-ready level. Stays high until acknowledged.
- `rx_data`  in  WIDTH  receiver byte; valid while `rx_rdy`.
- `rx_done`  out  1  one-cycle acknowledge pulse to the receiver `done` input.
- `rd`  in  1  pop strobe: `rd & ioenb & iowadr==2`.
- `clr`  in  1  flush strobe: `wr & ioenb & iowadr==3 & outbus[1]`.
- `dout`  out  WIDTH  head-of-FIFO byte; 0 when empty.
- `rdy`  out  1  FIFO not empty. Replaces `rdyRx` in status bit 0.
- `count`  out  DEPTH_LOG2+1  current occupancy.
- `ovf`  out  1  sticky overflow flag. Status bit 2.

## Operation
- The capture FSM has three states.
  - IDLE: if `rx_rdy`=1, attempt a push of `rx_data`, set `rx_done`<=1, go to ACK.
  - ACK: set `rx_done`<=0, go to HOLD.
  - HOLD: stay until `rx_rdy`=0, then go to IDLE. This prevents double capture while the receiver clears `rdy`.
- Push rule: a push succeeds if `count` < DEPTH, or if `rd` pops in the same cycle.
  - Otherwise the byte is discarded and `ovf`<=1.
  - `rx_done` is pulsed either way, so the receiver is always released.
- Pop rule: `rd` with `count`>0 advances the read pointer at the clock edge. `rd` on empty is ignored.
- `dout` is driven combinationally as `mem[rd_ptr]` (show-ahead). The bus therefore samples the head in the same cycle that `rd` pops it.
- Simultaneous push and pop: both take effect and `count` is unchanged. This includes the full case, where no overflow occurs.
- `clr` priority: `clr` beats push and pop. It zeroes the pointers, `count` and `ovf`.
  - A push attempted in the same cycle is lost.
  - The FSM is not affected, so `rx_done` is still pulsed.
- Pointers are DEPTH_LOG2 bits and wrap modulo DEPTH. `count` is DEPTH_LOG2+1 bits, so full (=DEPTH) is distinguishable from empty.
- Reset values:
  - FSM = IDLE.
  - `rx_done`=0, `rdy`=0, `count`=0, `ovf`=0, `dout`=0.
  - Pointers = 0. Memory contents are unspecified.
- Reset asserted mid-operation returns to IDLE immediately. A receiver left with `rx_rdy`=1 is re-captured after reset release.

## Timing
- Edge E0: `rx_rdy` is sampled high in IDLE. The byte is written, `count` increments, and `rdy` is high after E0.
- `rx_done` is high from E0 to E1. The receiver sees it at E1 and drops `rx_rdy` after E1.
- E1: ACK→HOLD. E2: `rx_rdy`=0, HOLD→IDLE.
- Minimum spacing is 3 cycles per byte, far above the 115200-baud arrival rate.
- Pop: `dout` and `rdy` update in the cycle after the `rd` edge.
- All outputs are registered except `dout`, which is a memory read (LUT-RAM, asynchronous read).

## Structure
- Shared package `rs232_pkg`:
  - `RXF_DEPTH_LOG2_DEFAULT` = 4.
  - FSM state enum {IDLE, ACK, HOLD}, 2 bits.
  - Status bit positions: RDY=0, TXRDY=1, OVF=2. The CLR control bit = 1.
- One sub-module, `byte_fifo`, holds the memory, pointers, `count` and the push/pop/clr arithmetic. `rs232_rx_fifo` holds the capture FSM, `rx_done` and `ovf`.

## Test plan
- Reset release with `rx_rdy`=0 → all outputs 0. Then inject `rx_data`=8'h41 → `rx_done` high exactly 1 cycle, then `rdy`=1, `dout`=8'h41, `count`=1.
- Push 16 bytes 8'h00..8'h0F, then a 17th byte 8'hAA → `count`=16, `ovf`=1, `rx_done` still pulsed. Popping 16 times yields 00..0F in order and never AA.
- FIFO full, and a push of 8'h55 coincides with `rd` → `count` stays 16, `ovf`=0, and 8'h55 is the last byte read.
- `rx_rdy` held high for 5 cycles after `rx_done` → exactly one capture (`count`=1), FSM stays in HOLD until `rx_rdy` falls.
- `clr` in the same cycle as a capture with `count`=3, `ovf`=1 → `count`=0, `ovf`=0, `rdy`=0, `rx_done` still pulsed.
- `rst` asserted between E0 and E1 → `rx_done` drops asynchronously and `count`=0. After release with `rx_rdy` still high, the byte is captured once.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared definitions for the RS-232 receive path: capture FSM encoding,
// default FIFO depth, and bit positions in the I/O status/control words.
package rs232_pkg;

   localparam int RXF_DEPTH_LOG2_DEFAULT = 4;

   typedef logic [1:0] rx_state_t;
   localparam rx_state_t ST_IDLE = 2'd0;
   localparam rx_state_t ST_ACK  = 2'd1;
   localparam rx_state_t ST_HOLD = 2'd2;

   // Status word (I/O word 3) read bits, and the control bit that flushes the FIFO.
   localparam int STAT_RDY   = 0;
   localparam int STAT_TXRDY = 1;
   localparam int STAT_OVF   = 2;
   localparam int CTRL_CLR   = 1;

endpackage

// File: rtl/byte_fifo.sv
// Show-ahead byte FIFO: LUT-RAM storage, wrapping pointers, occupancy count,
// and push/pop/flush arithmetic with flush taking priority.
module byte_fifo
   import rs232_pkg::*;
#(
   parameter int DEPTH_LOG2 = RXF_DEPTH_LOG2_DEFAULT,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  clr,
   input  logic [WIDTH-1:0]      din,
   output logic                  accept,
   output logic [WIDTH-1:0]      dout,
   output logic [DEPTH_LOG2:0]   count
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic                  pop_ok;
   logic                  do_push;
   logic                  do_pop;

   // A full FIFO still accepts a byte when the same edge frees the head slot.
   assign pop_ok  = pop && (count != '0);
   assign accept  = push && ((count != FULL) || pop_ok);
   assign do_push = accept && !clr;
   assign do_pop  = pop_ok && !clr;

   assign dout = (count == '0) ? '0 : mem[rd_ptr];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         if (do_push && !do_pop)      count <= count + 1'b1;
         else if (do_pop && !do_push) count <= count - 1'b1;
      end
   end

   // NOTE: storage has no reset so it maps onto LUT-RAM; empty reads are masked to 0 above.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive buffer between the RS-232 receiver and the I/O bus: captures each
// ready byte once, acknowledges it with a one-cycle pulse, and queues it.
module rs232_rx_fifo
   import rs232_pkg::*;
#(
   parameter int DEPTH_LOG2 = RXF_DEPTH_LOG2_DEFAULT,
   parameter int WIDTH      = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rx_rdy,
   input  logic [WIDTH-1:0]      rx_data,
   output logic                  rx_done,
   input  logic                  rd,
   input  logic                  clr,
   output logic [WIDTH-1:0]      dout,
   output logic                  rdy,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  ovf
);

   rx_state_t state;
   logic      push;
   logic      accept;

   assign push = (state == ST_IDLE) && rx_rdy;
   assign rdy  = (count != '0);

   byte_fifo #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .WIDTH      (WIDTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (rd),
      .clr    (clr),
      .din    (rx_data),
      .accept (accept),
      .dout   (dout),
      .count  (count)
   );

   // HOLD waits for the receiver to drop rx_rdy so one byte is never captured twice.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         rx_done <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: if (rx_rdy) begin
               rx_done <= 1'b1;
               state   <= ST_ACK;
            end
            ST_ACK: begin
               rx_done <= 1'b0;
               state   <= ST_HOLD;
            end
            ST_HOLD: if (!rx_rdy) state <= ST_IDLE;
            default: begin
               rx_done <= 1'b0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   ovf <= 1'b0;
      else if (clr)               ovf <= 1'b0;
      else if (push && !accept)   ovf <= 1'b1;
   end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed self-checking bench for rs232_rx_fifo: inputs change and outputs
// are sampled on the falling clock edge, away from the active rising edge.
module tb_rs232_rx_fifo;
   import rs232_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic       rx_rdy;
   logic [7:0] rx_data;
   logic       rx_done;
   logic       rd;
   logic       clr;
   logic [7:0] dout;
   logic       rdy;
   logic [4:0] count;
   logic       ovf;

   int n_checks = 0;
   int n_fails  = 0;

   rs232_rx_fifo #(.DEPTH_LOG2(4), .WIDTH(8)) dut (
      .clk     (clk),
      .rst     (rst),
      .rx_rdy  (rx_rdy),
      .rx_data (rx_data),
      .rx_done (rx_done),
      .rd      (rd),
      .clr     (clr),
      .dout    (dout),
      .rdy     (rdy),
      .count   (count),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Receiver model: raise rx_rdy, wait (bounded) for rx_done, drop rx_rdy after
   // the ack edge, and leave one cycle for the capture FSM to return to IDLE.
   task automatic send(input logic [7:0] b);
      int n;
      rx_data = b;
      rx_rdy  = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rx_done && n < 8);
      check("send_ack", rx_done, 1);
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
   endtask

   task automatic pop_check(input string tag, input logic [7:0] exp);
      check(tag, dout, exp);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "bench timed out");
   end

   initial begin
      rst = 1'b0; rx_rdy = 1'b0; rx_data = '0; rd = 1'b0; clr = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("rst_rx_done", rx_done, 0);
      check("rst_rdy",     rdy,     0);
      check("rst_dout",    dout,    0);
      check("rst_count",   count,   0);
      check("rst_ovf",     ovf,     0);

      // First capture: one-cycle acknowledge, byte visible at the head.
      rx_data = 8'h41; rx_rdy = 1'b1;
      @(negedge clk);
      check("cap_done_hi", rx_done, 1);
      check("cap_rdy",     rdy,     1);
      check("cap_count",   count,   1);
      check("cap_dout",    dout,    8'h41);
      @(negedge clk);
      check("cap_done_lo", rx_done, 0);
      rx_rdy = 1'b0;
      @(negedge clk);
      pop_check("pop_41", 8'h41);
      check("pop_count0", count, 0);
      check("pop_rdy0",   rdy,   0);
      check("pop_dout0",  dout,  0);

      // Fill, overflow with AA, then drain in order.
      for (int i = 0; i < 16; i++) send(8'(i));
      check("full_count", count, 16);
      check("full_ovf0",  ovf,   0);
      send(8'hAA);
      check("ovf_count", count, 16);
      check("ovf_set",   ovf,   1);
      for (int i = 0; i < 16; i++) pop_check("drain", 8'(i));
      check("drain_count", count, 0);
      check("drain_rdy",   rdy,   0);
      check("ovf_sticky",  ovf,   1);
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("pop_empty_count", count, 0);
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clr_ovf", ovf, 0);

      // Full FIFO: push of 55 coincides with a pop, no overflow.
      for (int i = 0; i < 16; i++) send(8'h10 + 8'(i));
      rx_data = 8'h55; rx_rdy = 1'b1; rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
      check("pp_done",  rx_done, 1);
      check("pp_count", count,   16);
      check("pp_ovf",   ovf,     0);
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);
      for (int i = 1; i < 16; i++) pop_check("pp_drain", 8'h10 + 8'(i));
      pop_check("pp_last", 8'h55);
      check("pp_empty", count, 0);
      check("pp_ovf_end", ovf, 0);

      // rx_rdy held high long after the ack: one capture, FSM parked in HOLD.
      rx_data = 8'h77; rx_rdy = 1'b1;
      @(negedge clk);
      check("hold_done", rx_done, 1);
      repeat (5) @(negedge clk);
      check("hold_count",   count,     1);
      check("hold_done_lo", rx_done,   0);
      check("hold_state",   dut.state, ST_HOLD);
      rx_rdy = 1'b0;
      @(negedge clk);
      check("hold_idle",  dut.state, ST_IDLE);
      check("hold_count2", count,    1);
      pop_check("hold_pop", 8'h77);

      // Flush on the same edge as a capture, with count=3 and ovf=1.
      for (int i = 0; i < 16; i++) send(8'h20 + 8'(i));
      send(8'hEE);
      check("c_ovf_pre", ovf, 1);
      for (int i = 0; i < 13; i++) pop_check("c_drain", 8'h20 + 8'(i));
      check("c_count_pre", count, 3);
      rx_data = 8'h99; rx_rdy = 1'b1; clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("c_done",  rx_done, 1);
      check("c_count", count,   0);
      check("c_ovf",   ovf,     0);
      check("c_rdy",   rdy,     0);
      check("c_dout",  dout,    0);
      @(negedge clk);
      rx_rdy = 1'b0;
      @(negedge clk);

      // Reset between E0 and E1, receiver still presenting the byte.
      rx_data = 8'hC3; rx_rdy = 1'b1;
      @(negedge clk);
      check("r_done_pre",  rx_done, 1);
      check("r_count_pre", count,   1);
      #1 rst = 1'b0;
      #1;
      check("r_done_async",  rx_done, 0);
      check("r_count_async", count,   0);
      check("r_rdy_async",   rdy,     0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("r_recap_done",  rx_done, 1);
      check("r_recap_count", count,   1);
      check("r_recap_dout",  dout,    8'hC3);
      rx_rdy = 1'b0;
      @(negedge clk);
      check("r_done_lo", rx_done, 0);
      repeat (3) @(negedge clk);
      check("r_once", count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
